// File: rtl/vec_mem_responder_pkg.sv
// Shared vector-side definitions for the burst memory responder:
// element geometry, burst length limits and FSM state encodings.
package vec_mem_responder_pkg;

  localparam int unsigned VL_MAX = 8;
  localparam int unsigned ELEM_W = 32;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned LEN_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // A burst base must sit on a 32-bit word boundary.
  function automatic logic word_aligned(input logic [1:0] byte_lsb);
    return byte_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/vec_mem_array.sv
// Word-addressed element storage: one synchronous write port, one
// combinational read port, no reset so it maps onto distributed RAM.
module vec_mem_array
  import vec_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ELEM_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ELEM_W-1:0] rdata
);

  logic [ELEM_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/vec_mem_responder.sv
// Target end of the vector load/store element-stream protocol: accepts one
// burst request, then streams load elements out or absorbs store elements.
module vec_mem_responder
  import vec_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned MAX_VL = VL_MAX
) (
  input  logic        clk_V,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_base,
  input  logic [3:0]  req_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic [2:0]  rdata_idx,
  output logic        done,
  output logic        err
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [1:0]        state, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic              err_d;
  logic              rd_load;
  logic              wr_en;
  logic [ADDR_W-1:0] elem_addr;
  logic [ELEM_W-1:0] mem_rdata;
  logic              unused_base_hi;

  // Upper byte-address bits beyond the array are deliberately ignored.
  assign unused_base_hi = ^{req_base[31:ADDR_W+2]};

  assign cnt_inc     = cnt_q + LEN_W'(1);
  assign elem_addr   = ADDR_W'(base_q + ADDR_W'(cnt_q));
  assign req_ready   = (state == ST_IDLE);
  assign wdata_ready = (state == ST_WR);

  always_ff @(posedge clk_V or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and burst bookkeeping.
  always_comb begin
    state_d = state;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    rd_load = 1'b0;
    wr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          base_d = req_base[ADDR_W+1:2];
          len_d  = req_len;
          cnt_d  = '0;
          if (!word_aligned(req_base[1:0]) || (32'(req_len) > MAX_VL)) begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end else if (req_len == '0) begin
            state_d = ST_FIN;
          end else if (req_store) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        // Refill the output register whenever it is empty or being drained.
        if ((!rdata_valid || rdata_ready) && (cnt_q != len_q)) begin
          rd_load = 1'b1;
          cnt_d   = cnt_inc;
        end else if (rdata_valid && rdata_ready) begin
          state_d = ST_FIN;
        end
      end
      ST_WR: begin
        if (wdata_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered burst context and output stream.
  always_ff @(posedge clk_V or posedge reset) begin
    if (reset) begin
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rdata       <= '0;
      rdata_idx   <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      if (rd_load) begin
        rdata       <= mem_rdata;
        rdata_idx   <= IDX_W'(cnt_q);
        rdata_valid <= 1'b1;
      end else if ((state == ST_RD) && rdata_ready) begin
        rdata_valid <= 1'b0;
      end
      done <= (state_d == ST_FIN);
      err  <= err_d;
    end
  end

  vec_mem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk_V),
    .we   (wr_en),
    .waddr(elem_addr),
    .wdata(wdata),
    .raddr(elem_addr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_vec_mem_responder.sv
// Directed bench for vec_mem_responder: store/load bursts, stalls, address
// wrap, rejected requests, reset mid-burst and back-to-back requests.
module tb_vec_mem_responder;

  logic        clk_V;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_base;
  logic [3:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic        rdata_ready;
  logic [31:0] rdata;
  logic [2:0]  rdata_idx;
  logic        done;
  logic        err;

  int n_checks;
  int n_fail;

  logic [31:0] got_d [16];
  logic [2:0]  got_i [16];
  int          got_n;
  int          done_at;
  int          stab_bad;

  vec_mem_responder #(.DEPTH(256), .MAX_VL(8)) dut (
    .clk_V      (clk_V),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_base   (req_base),
    .req_len    (req_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata_ready(rdata_ready),
    .rdata      (rdata),
    .rdata_idx  (rdata_idx),
    .done       (done),
    .err        (err)
  );

  initial begin
    clk_V = 1'b0;
    forever #5 clk_V = ~clk_V;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_V);
    #1;
  endtask

  // Presents a request for exactly one edge; caller ensures the DUT is idle.
  task automatic send_req(input logic st, input logic [31:0] base, input logic [3:0] len);
    req_valid = 1'b1;
    req_store = st;
    req_base  = base;
    req_len   = len;
    tick();
    req_valid = 1'b0;
  endtask

  // Drains a load burst right after acceptance; records handshaken elements,
  // the cycle done was seen, and any change of a stalled element.
  task automatic collect_load(input int budget, input bit toggle);
    logic        prev_stall;
    logic [31:0] prev_d;
    logic [2:0]  prev_i;
    got_n      = 0;
    done_at    = -1;
    stab_bad   = 0;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_i     = '0;
    for (int k = 0; k < 16; k++) begin
      got_d[k] = '0;
      got_i[k] = '0;
    end
    for (int c = 0; c < budget; c++) begin
      if (done) begin
        done_at = c;
        break;
      end
      rdata_ready = toggle ? ((c % 2) == 0) : 1'b1;
      if (prev_stall && (!rdata_valid || rdata !== prev_d || rdata_idx !== prev_i)) stab_bad++;
      prev_stall = rdata_valid && !rdata_ready;
      prev_d     = rdata;
      prev_i     = rdata_idx;
      if (rdata_valid && rdata_ready && got_n < 16) begin
        got_d[got_n] = rdata;
        got_i[got_n] = rdata_idx;
        got_n++;
      end
      tick();
    end
    rdata_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_store   = 1'b0;
    req_base    = '0;
    req_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    rdata_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (wdata_ready !== 1'b0) begin n_fail++; $display("FAIL reset_wdata_ready: got %b expected 0", wdata_ready); end
    n_checks++; if (rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid: got %b expected 0", rdata_valid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (rdata_idx !== 3'd0) begin n_fail++; $display("FAIL reset_rdata_idx: got %0d expected 0", rdata_idx); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    logic [31:0] d [4];
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
    send_req(1'b1, 32'h40, 4'd4);
    n_checks++; if (wdata_ready !== 1'b1) begin n_fail++; $display("FAIL st_wdata_ready: got %b expected 1", wdata_ready); end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        wdata_valid = 1'b0;
        wdata       = 32'hBAD0_BAD0;
        tick();
      end
      wdata_valid = 1'b1;
      wdata       = d[i];
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL st_early_done: got %b expected 0 before write %0d", done, i); end
      tick();
    end
    wdata_valid = 1'b0;
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL st_done: got done=%b err=%b expected 1 0", done, err); end
    tick();
    n_checks++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL st_idle: got done=%b req_ready=%b expected 0 1", done, req_ready); end
    send_req(1'b0, 32'h40, 4'd4);
    collect_load(30, 1'b0);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL ld_count: got %0d expected 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[i] !== d[i] || got_i[i] !== 3'(i)) begin
        n_fail++; $display("FAIL ld_elem%0d: got %h idx %0d expected %h idx %0d", i, got_d[i], got_i[i], d[i], i);
      end
    end
    n_checks++; if (done_at !== 5 || err !== 1'b0) begin n_fail++; $display("FAIL ld_done: got cycle %0d err %b expected 5 0", done_at, err); end
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ld_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_load_stall();
    send_req(1'b1, 32'h100, 4'd8);
    for (int i = 0; i < 8; i++) begin
      wdata_valid = 1'b1;
      wdata       = 32'hC0DE_0000 + 32'(i);
      tick();
    end
    wdata_valid = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL st8_done: got %b expected 1", done); end
    tick();
    send_req(1'b0, 32'h100, 4'd8);
    collect_load(40, 1'b0);
    n_checks++; if (got_n !== 8 || done_at !== 9) begin n_fail++; $display("FAIL ld8_nostall: got %0d elems done %0d expected 8 9", got_n, done_at); end
    tick();
    send_req(1'b0, 32'h100, 4'd8);
    collect_load(60, 1'b1);
    n_checks++; if (got_n !== 8) begin n_fail++; $display("FAIL ld8_toggle_count: got %0d expected 8", got_n); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (got_d[i] !== (32'hC0DE_0000 + 32'(i)) || got_i[i] !== 3'(i)) begin
        n_fail++; $display("FAIL ld8_elem%0d: got %h idx %0d expected %h idx %0d", i, got_d[i], got_i[i], 32'hC0DE_0000 + 32'(i), i);
      end
    end
    n_checks++; if (stab_bad !== 0) begin n_fail++; $display("FAIL ld8_stable: got %0d changes expected 0", stab_bad); end
    n_checks++; if (done_at !== 17) begin n_fail++; $display("FAIL ld8_toggle_done: got %0d expected 17", done_at); end
    tick();
  endtask

  task automatic test_wrap();
    send_req(1'b1, 32'h0000_03F8, 4'd4);
    for (int i = 0; i < 4; i++) begin
      wdata_valid = 1'b1;
      wdata       = 32'hA0 + 32'(i);
      tick();
    end
    wdata_valid = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_st_done: got %b expected 1", done); end
    tick();
    send_req(1'b0, 32'hABCD_03F8, 4'd4);
    collect_load(30, 1'b0);
    n_checks++; if (got_n !== 4) begin n_fail++; $display("FAIL wrap_ld_count: got %0d expected 4", got_n); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_d[i] !== (32'hA0 + 32'(i))) begin n_fail++; $display("FAIL wrap_ld%0d: got %h expected %h", i, got_d[i], 32'hA0 + 32'(i)); end
    end
    tick();
    send_req(1'b0, 32'h0, 4'd2);
    collect_load(30, 1'b0);
    n_checks++;
    if (got_n !== 2 || got_d[0] !== 32'hA2 || got_d[1] !== 32'hA3) begin
      n_fail++; $display("FAIL wrap_word0: got n=%0d %h %h expected 2 a2 a3", got_n, got_d[0], got_d[1]);
    end
    tick();
  endtask

  task automatic test_errors();
    send_req(1'b0, 32'h42, 4'd2);
    n_checks++; if (done !== 1'b1 || err !== 1'b1 || rdata_valid !== 1'b0) begin n_fail++; $display("FAIL err_misalign: got done=%b err=%b rv=%b expected 1 1 0", done, err, rdata_valid); end
    tick();
    n_checks++; if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL err_clear: got done=%b err=%b rr=%b expected 0 0 1", done, err, req_ready); end
    wdata_valid = 1'b1;
    wdata       = 32'hDEAD_BEEF;
    send_req(1'b1, 32'h40, 4'd9);
    n_checks++; if (done !== 1'b1 || err !== 1'b1 || wdata_ready !== 1'b0) begin n_fail++; $display("FAIL err_len9: got done=%b err=%b wr=%b expected 1 1 0", done, err, wdata_ready); end
    tick();
    wdata_valid = 1'b0;
    send_req(1'b0, 32'h40, 4'd0);
    n_checks++; if (done !== 1'b1 || err !== 1'b0 || rdata_valid !== 1'b0) begin n_fail++; $display("FAIL len0: got done=%b err=%b rv=%b expected 1 0 0", done, err, rdata_valid); end
    tick();
    send_req(1'b0, 32'h40, 4'd1);
    collect_load(20, 1'b0);
    n_checks++; if (got_n !== 1 || got_d[0] !== 32'h11 || done_at !== 2) begin n_fail++; $display("FAIL err_nowrite: got n=%0d %h done %0d expected 1 11 2", got_n, got_d[0], done_at); end
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen;
    send_req(1'b1, 32'h80, 4'd6);
    for (int i = 0; i < 2; i++) begin
      wdata_valid = 1'b1;
      wdata       = 32'hBEEF_0000 + 32'(i);
      tick();
    end
    wdata_valid = 1'b0;
    reset       = 1'b1;
    #1;
    n_checks++; if (wdata_ready !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got wr=%b rr=%b expected 0 1", wdata_ready, req_ready); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0 || rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: got done=%b err=%b rv=%b expected 0 0 0", done, err, rdata_valid); end
    tick();
    reset     = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) done_seen++;
      tick();
    end
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d pulses expected 0", done_seen); end
    send_req(1'b0, 32'h80, 4'd2);
    collect_load(20, 1'b0);
    n_checks++;
    if (got_n !== 2 || got_d[0] !== 32'hBEEF_0000 || got_d[1] !== 32'hBEEF_0001 || done_at !== 3) begin
      n_fail++; $display("FAIL rst_mid_keep: got n=%0d %h %h done %0d expected 2 beef0000 beef0001 3", got_n, got_d[0], got_d[1], done_at);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc_c [4];
    int done_c [4];
    int na;
    int nd;
    int hs;
    na = 0; nd = 0; hs = 0;
    for (int k = 0; k < 4; k++) begin acc_c[k] = -1; done_c[k] = -1; end
    req_valid   = 1'b1;
    req_store   = 1'b0;
    req_base    = 32'h40;
    req_len     = 4'd2;
    rdata_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (done && nd < 4) begin done_c[nd] = c; nd++; end
      if (req_valid && req_ready && na < 4) begin acc_c[na] = c; na++; end
      if (rdata_valid && rdata_ready) hs++;
      tick();
      if (na >= 2) req_valid = 1'b0;
    end
    req_valid   = 1'b0;
    rdata_ready = 1'b0;
    n_checks++; if (na !== 2 || acc_c[0] !== 0 || acc_c[1] !== 5) begin n_fail++; $display("FAIL b2b_accept: got n=%0d at %0d,%0d expected 2 at 0,5", na, acc_c[0], acc_c[1]); end
    n_checks++; if (nd !== 2 || done_c[0] !== 4 || done_c[1] !== 9) begin n_fail++; $display("FAIL b2b_done: got n=%0d at %0d,%0d expected 2 at 4,9", nd, done_c[0], done_c[1]); end
    n_checks++; if (hs !== 4) begin n_fail++; $display("FAIL b2b_handshakes: got %0d expected 4", hs); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_store_load();
    test_load_stall();
    test_wrap();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_responder.md
# vec_mem_responder

Burst-capable memory responder on the vector side of the core: the target end of the vector load/store unit's element-stream protocol. Accepts one burst request (base address, element count up to the vector length, load or store), then streams load elements out, or absorbs store elements, one 32-bit word per cycle under valid/ready flow control, and signals completion. Owns its own word-addressed storage array and sits beside the scalar data memory in the `clk_V` domain.

## Interface
- `DEPTH`, 256, number of 32-bit words in the array (power of two)
- `MAX_VL`, 8, maximum elements per burst (matches vector register count)
- `clk_V`  in  1  vector-domain clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  burst request present
- `req_ready`  out  1  responder can accept a request
- `req_store`  in  1  1 = store burst, 0 = load burst
- `req_base`  in  32  byte address of element 0
- `req_len`  in  4  element count, legal 0..MAX_VL
- `wdata_valid`  in  1  store element present
- `wdata_ready`  out  1  responder accepts store element
- `wdata`  in  32  store element
- `rdata_valid`  out  1  load element present
- `rdata_ready`  in  1  initiator accepts load element
- `rdata`  out  32  load element
- `rdata_idx`  out  3  element index of `rdata` (0..MAX_VL-1)
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; request rejected

## Operation
- States: IDLE, RD, WR, FIN.
- IDLE: `req_ready`=1. On `req_valid`: latch base word index `req_base[log2(DEPTH)+1:2]`, length, reset element counter to 0.
  - `req_base[1:0]`≠0 or `req_len`>MAX_VL → FIN with err=1, no array access.
  - `req_len`=0 → FIN with err=0, no data.
  - else → RD (load) or WR (store).
- RD: when `rdata_valid`=0 or `rdata_ready`=1, and elements remain, register `rdata`←array[(base+cnt) mod DEPTH], `rdata_idx`←cnt, `rdata_valid`←1, cnt+1. When last element handshakes (`rdata_valid`&`rdata_ready`, cnt=len) → `rdata_valid`←0, go FIN. `rdata`/`rdata_idx` stable while `rdata_valid`=1 and `rdata_ready`=0.
- WR: `wdata_ready`=1. Each `wdata_valid` cycle writes array[(base+cnt) mod DEPTH]←`wdata` at that edge, cnt+1. After the len-th write → FIN.
- FIN: `done`=1 for one cycle, `err` as latched; → IDLE.
- Address arithmetic: word index width log2(DEPTH), wraps modulo DEPTH; upper address bits ignored.
- Array contents not cleared by reset; persistent across bursts and resets.

## Timing
- Reset values: state IDLE, `req_ready`=1 (combinational from IDLE), `wdata_ready`=0, `rdata_valid`=0, `rdata`=0, `rdata_idx`=0, `done`=0, `err`=0.
- Load: request accepted at edge E; element 0 valid after E+1; with `rdata_ready` held high one element per cycle; `done` in cycle after final handshake. Len=8 load, no stalls: `done` visible after E+9 ... E+10 window exactly one cycle.
- Store: `wdata_ready` high from cycle after acceptance; len writes at ≥len edges; `done` the cycle after last write.
- Error/zero-length: `done` one cycle after acceptance.
- One burst outstanding; no new request accepted until back in IDLE (earliest cycle after `done`).
- `wdata_valid` outside WR ignored; `rdata_ready` outside RD ignored.
- Reset mid-burst: immediate return to IDLE, outputs to reset values, no `done`; store words already written remain.

## Structure
- Shared vector package: `MAX_VL`, element width 32, state enum (IDLE/RD/WR/FIN), element-index width.
- Single module plus one sub-module `vec_mem_array` (DEPTH×32, one write port, combinational read), so storage maps to distributed RAM.

## Test plan
- Store len=4 base 0x40, data 0x11,0x22,0x33,0x44 → 4 writes, `done` once; then load len=4 base 0x40 → rdata 0x11..0x44, idx 0..3, `done`, err=0.
- Load len=8 with `rdata_ready` toggling 1,0,1,0 → each element held stable while stalled, 8 unique handshakes, order preserved.
- Base 0x3F8 (DEPTH=256), store len=4 → words 254,255,0,1 written (wrap); reload confirms.
- Base 0x42, len=2 → `done`=1,`err`=1 one cycle after accept, no data; len=9 → same; len=0 → `done`=1,`err`=0.
- Reset asserted after 2nd of 6 store elements → outputs to reset values immediately, no `done`; next request accepted; first 2 words hold new data.
- Back-to-back: `req_valid` held high across two loads → second accepted only in cycle after first `done`.
